// File: rtl/regbank_arbiter_pkg.sv
// regbank_arbiter_pkg: shared widths, FSM state encoding and one-hot helper for the register-bank arbiter
package regbank_arbiter_pkg;
    localparam int REQ_N  = 3;
    localparam int REG_AW = 4;
    localparam int DATA_W = 32;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_WAIT,
        ST_RD_DONE,
        ST_WR_SETUP,
        ST_WR_FIRE
    } state_t;
    function automatic logic [REQ_N-1:0] onehot(input logic [1:0] idx);
        return REQ_N'(1) << idx;
    endfunction
endpackage

// File: rtl/regbank_rr_pick.sv
// regbank_rr_pick: combinational 3-way round-robin picker
//   req : per-requester request levels
//   ptr : requester with highest priority this round
//   idx : first requester at or after ptr with req high (ptr when none)
//   any : at least one request present
module regbank_rr_pick
    import regbank_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       idx,
    output logic             any
);
    int c;
    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        idx = ptr;
        c = 0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            c = c >= REQ_N ? c - REQ_N : c;
            idx = req[2'(c)] ? 2'(c) : idx;
        end
    end
    assign any = |req;
endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: arbitrates three readers and one writer onto a toggle-triggered register bank
//   clk, resetN                  : clock, asynchronous active-low reset
//   rdReq, rdAddr0..2            : read requests (level) and register indices
//   rdGnt, rdData                : one-hot grant pulse with read result in the same cycle
//   wrReq, wrAddr, wrData, wrAck : write request (level), address, data, issue pulse
//   bankTrigR, bankAddrR         : bank read trigger (toggle per read) and address
//   bankReady, bankData          : bank read-ready (asynchronous) and read data
//   bankTrigW, bankAddrW, bankDataW : bank write trigger (toggle per write), address, data
//   errTimeout                   : sticky flag, a bank read timed out
module regbank_arbiter
    import regbank_arbiter_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [REQ_N-1:0]  rdReq,
    input  logic [REG_AW-1:0] rdAddr0,
    input  logic [REG_AW-1:0] rdAddr1,
    input  logic [REG_AW-1:0] rdAddr2,
    output logic [REQ_N-1:0]  rdGnt,
    output logic [DATA_W-1:0] rdData,
    input  logic              wrReq,
    input  logic [REG_AW-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrAck,
    output logic              bankTrigR,
    output logic [REG_AW-1:0] bankAddrR,
    input  logic              bankReady,
    input  logic [DATA_W-1:0] bankData,
    output logic              bankTrigW,
    output logic [REG_AW-1:0] bankAddrW,
    output logic [DATA_W-1:0] bankDataW,
    output logic              errTimeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t            state, nxt;
    logic [1:0]        win, rr_ptr, pick_idx;
    logic              pick_any, last_wr, rd_ok, rd_to;
    logic [1:0]        sync;
    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] pick_addr;
    regbank_rr_pick u_pick (
        .req(rdReq),
        .ptr(rr_ptr),
        .idx(pick_idx),
        .any(pick_any)
    );
    assign pick_addr = pick_idx == 2'd0 ? rdAddr0 : pick_idx == 2'd1 ? rdAddr1 : rdAddr2;
    assign rd_ok = cnt >= CW'(RD_WAIT) && sync[1];
    // Leaving at TIMEOUT-1 places the grant TIMEOUT cycles after the trigger toggle.
    assign rd_to = cnt >= CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= ST_IDLE;
        else state <= nxt;
    end
    // A pending write goes first unless the previous operation was a write, so reads and writes alternate.
    always_comb begin
        nxt = state;
        rdGnt = '0;
        wrAck = 1'b0;
        case (state)
            ST_IDLE:     nxt = (wrReq && !last_wr) ? ST_WR_SETUP : pick_any ? ST_RD_SETUP : wrReq ? ST_WR_SETUP : ST_IDLE;
            ST_RD_SETUP: nxt = ST_RD_WAIT;
            ST_RD_WAIT:  nxt = (rd_ok || rd_to) ? ST_RD_DONE : ST_RD_WAIT;
            ST_RD_DONE: begin
                nxt = ST_IDLE;
                rdGnt = onehot(win);
            end
            ST_WR_SETUP: nxt = ST_WR_FIRE;
            ST_WR_FIRE: begin
                nxt = ST_IDLE;
                wrAck = 1'b1;
            end
            default:     nxt = ST_IDLE;
        endcase
    end
    // The winner and its address are captured on leaving IDLE, so a requester dropping early still gets its grant.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync       <= '0;
            win        <= '0;
            rr_ptr     <= '0;
            last_wr    <= 1'b0;
            cnt        <= '0;
            rdData     <= '0;
            bankTrigR  <= 1'b0;
            bankAddrR  <= '0;
            bankTrigW  <= 1'b0;
            bankAddrW  <= '0;
            bankDataW  <= '0;
            errTimeout <= 1'b0;
        end else begin
            sync <= {sync[0], bankReady};
            cnt  <= state == ST_RD_WAIT ? cnt + CW'(1) : '0;
            if (state == ST_IDLE && nxt == ST_RD_SETUP) begin
                win       <= pick_idx;
                bankAddrR <= pick_addr;
            end
            if (state == ST_RD_SETUP) bankTrigR <= ~bankTrigR;
            if (state == ST_RD_WAIT && nxt == ST_RD_DONE) begin
                rdData <= rd_ok ? bankData : '0;
                if (!rd_ok) errTimeout <= 1'b1;
            end
            if (state == ST_RD_DONE) begin
                rr_ptr  <= win == 2'd2 ? 2'd0 : win + 2'd1;
                last_wr <= 1'b0;
            end
            if (state == ST_IDLE && nxt == ST_WR_SETUP) begin
                bankAddrW <= wrAddr;
                bankDataW <= wrData;
            end
            if (state == ST_WR_SETUP) bankTrigW <= ~bankTrigW;
            if (state == ST_WR_FIRE) last_wr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: scoreboard bench for regbank_arbiter with a behavioural register bank
module tb_regbank_arbiter;
    typedef struct {
        bit          wr;
        logic [2:0]  gnt;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        resetN;
    logic [2:0]  rdReq;
    logic [3:0]  rdAddr0, rdAddr1, rdAddr2;
    logic [2:0]  rdGnt;
    logic [31:0] rdData;
    logic        wrReq;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    logic        wrAck;
    logic        bankTrigR;
    logic [3:0]  bankAddrR;
    logic        bankReady;
    logic [31:0] bankData;
    logic        bankTrigW;
    logic [3:0]  bankAddrW;
    logic [31:0] bankDataW;
    logic        errTimeout;
    logic [31:0] mem [16];
    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          trr = 0;
    int          trw = 0;
    logic        pr = 1'b0;
    logic        pw = 1'b0;
    regbank_arbiter dut (
        .clk(clk), .resetN(resetN),
        .rdReq(rdReq), .rdAddr0(rdAddr0), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
        .rdGnt(rdGnt), .rdData(rdData),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrAck(wrAck),
        .bankTrigR(bankTrigR), .bankAddrR(bankAddrR), .bankReady(bankReady), .bankData(bankData),
        .bankTrigW(bankTrigW), .bankAddrW(bankAddrW), .bankDataW(bankDataW),
        .errTimeout(errTimeout)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign bankData = mem[bankAddrR];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[5] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (bankTrigW !== pw) begin
                mem[bankAddrW] = bankDataW;
                trw++;
            end
            if (bankTrigR !== pr) trr++;
            pw = bankTrigW;
            pr = bankTrigR;
        end
    end
    always @(negedge clk) begin
        if (resetN && (rdGnt != 3'b000 || wrAck)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got wrAck=%0b rdGnt=%b rdData=%h at cyc %0d, want nothing", wrAck, rdGnt, rdData, cyc);
            end else begin
                e = sb.pop_front();
                if (wrAck !== e.wr || rdGnt !== (e.wr ? 3'b000 : e.gnt) || (!e.wr && rdData !== e.data) || (e.cyc >= 0 && cyc != e.cyc)) begin
                    bad++;
                    $display("FAIL scoreboard: got wrAck=%0b rdGnt=%b rdData=%h cyc=%0d, want wrAck=%0b rdGnt=%b rdData=%h cyc=%0d",
                             wrAck, rdGnt, rdData, cyc, e.wr, e.gnt, e.data, e.cyc);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_rdGnt"}, 32'(rdGnt), 32'h0);
        chk({tag, "_rdData"}, rdData, 32'h0);
        chk({tag, "_wrAck"}, 32'(wrAck), 32'h0);
        chk({tag, "_bankTrigR"}, 32'(bankTrigR), 32'h0);
        chk({tag, "_bankTrigW"}, 32'(bankTrigW), 32'h0);
        chk({tag, "_bankAddrR"}, 32'(bankAddrR), 32'h0);
        chk({tag, "_bankAddrW"}, 32'(bankAddrW), 32'h0);
        chk({tag, "_bankDataW"}, bankDataW, 32'h0);
        chk({tag, "_errTimeout"}, 32'(errTimeout), 32'h0);
    endtask
    task automatic run_evt(input int n, input bit drop_each, input string name);
        int seen = 0;
        for (int k = 0; k < 200 && seen < n; k++) begin
            @(negedge clk);
            if (rdGnt != 3'b000 || wrAck) begin
                seen++;
                if (seen == n) begin
                    rdReq = 3'b000;
                    wrReq = 1'b0;
                end else if (drop_each) begin
                    rdReq = rdReq & ~rdGnt;
                    wrReq = wrReq & ~wrAck;
                end
            end
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL %s_wait: got %0d events want %0d", name, seen, n);
            rdReq = 3'b000;
            wrReq = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int c, t0;
        resetN = 1'b0;
        rdReq = 3'b000;
        rdAddr0 = 4'd0;
        rdAddr1 = 4'd0;
        rdAddr2 = 4'd0;
        wrReq = 1'b0;
        wrAddr = 4'd0;
        wrData = 32'h0;
        bankReady = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        // round robin from pointer 0, all three held
        rdAddr0 = 4'd1;
        rdAddr1 = 4'd2;
        rdAddr2 = 4'd4;
        sb.push_back('{1'b0, 3'b001, 32'h1000_0001, -1});
        sb.push_back('{1'b0, 3'b010, 32'h1000_0002, -1});
        sb.push_back('{1'b0, 3'b100, 32'h1000_0004, -1});
        sb.push_back('{1'b0, 3'b001, 32'h1000_0001, -1});
        t0 = trr;
        rdReq = 3'b111;
        run_evt(4, 1'b0, "rr");
        chk("rr_trig_count", 32'(trr - t0), 32'd4);
        // single read, minimum latency
        rdAddr0 = 4'd5;
        c = cyc;
        t0 = trr;
        sb.push_back('{1'b0, 3'b001, 32'hDEAD_BEEF, c + 5});
        rdReq = 3'b001;
        run_evt(1, 1'b1, "single");
        chk("single_trig_count", 32'(trr - t0), 32'd1);
        // write and read alternate under contention
        wrAddr = 4'd9;
        wrData = 32'h0000_ABCD;
        rdAddr0 = 4'd8;
        t0 = trw;
        sb.push_back('{1'b1, 3'b000, 32'h0, -1});
        sb.push_back('{1'b0, 3'b001, 32'h1000_0008, -1});
        sb.push_back('{1'b1, 3'b000, 32'h0, -1});
        sb.push_back('{1'b0, 3'b001, 32'h1000_0008, -1});
        wrReq = 1'b1;
        rdReq = 3'b001;
        run_evt(4, 1'b0, "alt");
        chk("alt_trigw_count", 32'(trw - t0), 32'd2);
        chk("alt_addrw_hold", 32'(bankAddrW), 32'd9);
        chk("alt_dataw_hold", bankDataW, 32'h0000_ABCD);
        // read-after-write to the same register
        wrAddr = 4'd3;
        wrData = 32'h7;
        rdAddr0 = 4'd3;
        sb.push_back('{1'b1, 3'b000, 32'h0, -1});
        sb.push_back('{1'b0, 3'b001, 32'h7, -1});
        wrReq = 1'b1;
        rdReq = 3'b001;
        run_evt(2, 1'b1, "raw");
        // timeout with bank never ready
        bankReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_timeout_err", 32'(errTimeout), 32'h0);
        rdAddr1 = 4'd6;
        c = cyc;
        sb.push_back('{1'b0, 3'b010, 32'h0, c + 17});
        rdReq = 3'b010;
        run_evt(1, 1'b1, "timeout");
        chk("timeout_err", 32'(errTimeout), 32'h1);
        bankReady = 1'b1;
        repeat (5) @(negedge clk);
        chk("timeout_err_sticky", 32'(errTimeout), 32'h1);
        // reset in the middle of a read
        rdAddr2 = 4'd5;
        rdReq = 3'b100;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        #1;
        chk_zero("midrd");
        rdReq = 3'b000;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        rdAddr0 = 4'd5;
        c = cyc;
        sb.push_back('{1'b0, 3'b001, 32'hDEAD_BEEF, c + 5});
        rdReq = 3'b001;
        run_evt(1, 1'b1, "post_reset");
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 Parameter RD_WAIT, default 2: minimum cycles between read-trigger toggle and data capture.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait for bank ready before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 resetN  in  1  asynchronous, active-low reset.
REQ-005 rdReq  in  3  per-requester read request; level, held until matching rdGnt.
REQ-006 rdAddr0, rdAddr1, rdAddr2  in  4 each  register index per requester; stable while rdReq high.
REQ-007 rdGnt  out  3  one-hot, one-cycle pulse; rdData valid in same cycle.
REQ-008 rdData  out  32  read result.
REQ-009 wrReq  in  1  write request; level, held until wrAck.
REQ-010 wrAddr  in  4  write register index.
REQ-011 wrData  in  32  write data.
REQ-012 wrAck  out  1  one-cycle pulse when write issued.
REQ-013 bankTrigR  out  1  read trigger to bank; each toggle is one read.
REQ-014 bankAddrR  out  4  read address to bank.
REQ-015 bankReady  in  1  bank read-ready, asynchronous to clk.
REQ-016 bankData  in  32  bank read data.
REQ-017 bankTrigW  out  1  write trigger to bank; each toggle is one write.
REQ-018 bankAddrW, bankDataW  out  4 / 32  write address and data to bank.
REQ-019 errTimeout  out  1  sticky flag: bank read timed out.

Function
REQ-020 bankReady SHALL pass through a 2-flop synchronizer before use.
REQ-021 FSM states: IDLE, RD_SETUP, RD_WAIT, RD_DONE, WR_SETUP, WR_FIRE.
REQ-022 IDLE: wrReq with lastWasWrite=0 -> WR_SETUP; otherwise any rdReq -> RD_SETUP; otherwise wrReq -> WR_SETUP; none -> IDLE.
REQ-023 lastWasWrite set on WR_FIRE, cleared on RD_DONE: writes and reads alternate under contention; neither side starves.
REQ-024 Read selection: round-robin from pointer rrPtr; first requester at or after rrPtr with rdReq high; rrPtr <- winner+1 mod 3 on RD_DONE.
REQ-025 RD_SETUP (1 cycle): latch winner index, drive bankAddrR = winner address.
REQ-026 RD_WAIT entry toggles bankTrigR exactly once; cycle counter cleared.
REQ-027 RD_WAIT -> RD_DONE when counter >= RD_WAIT and synchronized ready = 1.
REQ-028 RD_WAIT -> RD_DONE with errTimeout set when counter reaches TIMEOUT without ready.
REQ-029 RD_DONE (1 cycle): rdData = bankData (32'h0 on timeout), rdGnt[winner]=1, -> IDLE.
REQ-030 Minimum read latency, request-seen-in-IDLE to rdGnt: RD_WAIT+3 cycles.
REQ-031 WR_SETUP (1 cycle): register bankAddrW, bankDataW from wrAddr, wrData.
REQ-032 WR_FIRE (1 cycle): toggle bankTrigW, wrAck=1, -> IDLE; write latency 2 cycles.
REQ-033 bankAddrW/bankDataW SHALL hold stable until the next WR_SETUP.
REQ-034 A read requested with the same address as a pending write, both seen in IDLE, with lastWasWrite=0: write SHALL complete first; read returns new data.
REQ-035 rdReq dropped before grant is a protocol violation; grant still issued to latched winner.
REQ-036 rdGnt one-hot or zero; rdGnt and wrAck never high in the same cycle.

Reset
REQ-037 resetN low SHALL immediately force: state IDLE, rdGnt=0, rdData=0, wrAck=0, bankTrigR=0, bankTrigW=0, bankAddrR=0, bankAddrW=0, bankDataW=0, errTimeout=0, rrPtr=0, lastWasWrite=0, synchronizer=0.
REQ-038 Reset mid-read or mid-write SHALL abandon the operation with no grant or ack; trigger levels return to 0 (the bank may see one extra edge; accepted).

Structure
REQ-039 Shared package holds FSM state enum, REQ_N=3, REG_AW=4, DATA_W=32.
REQ-040 One sub-module: regbank_rr_pick (combinational 3-way round-robin picker); synchronizer inline.

Verification
REQ-041 Single read: r5=32'hDEAD_BEEF in bank model, rdReq=3'b001, rdAddr0=5 -> one bankTrigR toggle, rdGnt=3'b001 with rdData=32'hDEAD_BEEF at cycle 5.
REQ-042 Round robin: rdReq=3'b111 held -> grants 001, 010, 100, 001 in order.
REQ-043 Write/read alternate: wrReq held plus rdReq=3'b001 held -> wrAck, rdGnt, wrAck, rdGnt alternate; bankTrigW toggles once per wrAck.
REQ-044 RAW ordering: wrAddr=3, wrData=7, rdAddr0=3, both raised together -> wrAck first, then rdData=7.
REQ-045 Timeout: bankReady tied 0, rdReq=3'b010 -> rdGnt=3'b010 with rdData=0 at 15 cycles after trigger toggle; errTimeout=1 until reset.
REQ-046 Reset during RD_WAIT -> no rdGnt, all outputs 0, next read completes normally.
